// File: rtl/edge_event_arbiter.sv
// rtl/edge_event_arbiter.sv - per-channel edge detection with round-robin valid/ready event delivery
module edge_event_arbiter #(
    parameter int NCH  = 4,
    parameter int CHW  = 2,
    parameter int CNTW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   i_din,
    input  logic [2*NCH-1:0] i_edge_sel,
    input  logic             i_clr,
    output logic             o_evt_valid,
    input  logic             i_evt_ready,
    output logic [CHW-1:0]   o_evt_ch,
    output logic             o_evt_type,
    output logic [NCH-1:0]   o_pend,
    output logic [NCH-1:0]   o_overflow,
    output logic [CNTW-1:0]  o_evt_cnt
);

    typedef enum logic {
        S_IDLE,
        S_PRESENT
    } state_t;

    state_t          r_state;
    logic            r_armed;
    logic [NCH-1:0]  r_prev;
    logic [NCH-1:0]  r_pend;
    logic [NCH-1:0]  r_ptyp;
    logic [NCH-1:0]  r_ovf;
    logic [CNTW-1:0] r_cnt;
    logic            r_valid;
    logic [CHW-1:0]  r_ch;
    logic            r_type;
    logic [CHW-1:0]  r_ptr;

    logic [NCH-1:0]  w_rise;
    logic [NCH-1:0]  w_fall;
    logic [NCH-1:0]  w_edge;
    logic [NCH-1:0]  w_rot;
    logic [CHW-1:0]  w_off;
    logic [CHW:0]    w_sum;
    logic [CHW-1:0]  w_sel;
    logic            w_load;
    logic [NCH-1:0]  w_load_vec;

    always_comb begin
        w_rise = '0;
        w_fall = '0;
        w_edge = '0;
        for (int i = 0; i < NCH; i++) begin
            w_rise[i] = ~r_prev[i] & i_din[i];
            w_fall[i] = r_prev[i] & ~i_din[i];
            w_edge[i] = r_armed & ((w_rise[i] & i_edge_sel[2*i]) |
                                   (w_fall[i] & i_edge_sel[2*i+1]));
        end
    end

    // Rotate pending so that bit 0 is the channel at ptr; lowest set bit wins.
    always_comb begin
        w_rot = NCH'({r_pend, r_pend} >> r_ptr);
        w_off = '0;
        for (int j = NCH - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = CHW'(j);
            end
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum >= (CHW+1)'(NCH)) begin
            w_sum = w_sum - (CHW+1)'(NCH);
        end
        w_sel = w_sum[CHW-1:0];
    end

    // A clear cycle never loads, so a cleared pend bit cannot slip into the output.
    assign w_load     = (r_state == S_IDLE) && (|r_pend) && !i_clr;
    assign w_load_vec = w_load ? (NCH'(1) << w_sel) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_armed <= 1'b0;
            r_prev  <= '0;
            r_pend  <= '0;
            r_ptyp  <= '0;
            r_ovf   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_ch    <= '0;
            r_type  <= 1'b0;
            r_ptr   <= '0;
        end else begin
            r_armed <= 1'b1;
            r_prev  <= i_din;

            if (i_clr) begin
                r_pend <= '0;
                r_ovf  <= '0;
            end else begin
                for (int i = 0; i < NCH; i++) begin
                    if (w_edge[i]) begin
                        if (r_pend[i] && !w_load_vec[i]) begin
                            r_ovf[i] <= 1'b1;
                        end else begin
                            r_pend[i] <= 1'b1;
                            r_ptyp[i] <= w_fall[i];
                        end
                    end else if (w_load_vec[i]) begin
                        r_pend[i] <= 1'b0;
                    end
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (i_clr) begin
                        r_cnt <= '0;
                    end
                    if (w_load) begin
                        r_ch    <= w_sel;
                        r_type  <= r_ptyp[w_sel];
                        r_valid <= 1'b1;
                        r_state <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (i_evt_ready) begin
                        r_valid <= 1'b0;
                        r_ptr   <= (r_ch == CHW'(NCH - 1)) ? '0 : r_ch + CHW'(1);
                        r_cnt   <= i_clr ? CNTW'(1) : r_cnt + CNTW'(1);
                        r_state <= S_IDLE;
                    end else if (i_clr) begin
                        r_cnt <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_evt_valid = r_valid;
    assign o_evt_ch    = r_ch;
    assign o_evt_type  = r_type;
    assign o_pend      = r_pend;
    assign o_overflow  = r_ovf;
    assign o_evt_cnt   = r_cnt;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb/tb_edge_event_arbiter.sv - directed scoreboard bench for edge_event_arbiter
module tb_edge_event_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] din;
    logic [7:0] edge_sel;
    logic       clr;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_ch;
    logic       evt_type;
    logic [3:0] pend;
    logic [3:0] overflow;
    logic [7:0] evt_cnt;

    typedef struct {
        logic [1:0] ch;
        logic       typ;
    } exp_t;

    exp_t sb[$];
    int   n_vec;
    int   n_err;

    edge_event_arbiter #(.NCH(4), .CHW(2), .CNTW(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_din       (din),
        .i_edge_sel  (edge_sel),
        .i_clr       (clr),
        .o_evt_valid (evt_valid),
        .i_evt_ready (evt_ready),
        .o_evt_ch    (evt_ch),
        .o_evt_type  (evt_type),
        .o_pend      (pend),
        .o_overflow  (overflow),
        .o_evt_cnt   (evt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] ch, input logic typ);
        exp_t e;
        e.ch  = ch;
        e.typ = typ;
        sb.push_back(e);
    endtask

    // Called at a falling edge: scores any handshake the next rising edge will take.
    task automatic tick();
        exp_t e;
        if (evt_valid && evt_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $error("FAIL unexpected_event: observed ch %0d type %0d expected none", evt_ch, evt_type);
            end else begin
                e = sb.pop_front();
                chk("sb_evt_ch", 32'(evt_ch), 32'(e.ch));
                chk("sb_evt_type", 32'(evt_type), 32'(e.typ));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        din       = 4'b1111;
        edge_sel  = 8'hFF;
        clr       = 1'b0;
        evt_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_pend", 32'(pend), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_cnt", 32'(evt_cnt), 0);
        chk("rst_ch", 32'(evt_ch), 0);
        chk("rst_type", 32'(evt_type), 0);

        rst = 1'b0;
        repeat (3) tick();
        chk("arm_pend", 32'(pend), 0);
        chk("arm_valid", 32'(evt_valid), 0);

        din[0] = 1'b0;
        push(2'd0, 1'b1);
        tick();
        chk("det_pend", 32'(pend), 1);
        chk("det_valid_early", 32'(evt_valid), 0);
        tick();
        chk("det_valid", 32'(evt_valid), 1);
        chk("det_ch", 32'(evt_ch), 0);
        chk("det_type", 32'(evt_type), 1);
        evt_ready = 1'b1;
        tick();
        chk("first_cnt", 32'(evt_cnt), 1);
        chk("first_valid_off", 32'(evt_valid), 0);

        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_idle_cnt", 32'(evt_cnt), 0);

        edge_sel = 8'h55;
        din = 4'b0000;
        repeat (2) tick();
        din = 4'b1110;
        push(2'd1, 1'b0);
        push(2'd2, 1'b0);
        push(2'd3, 1'b0);
        repeat (5) tick();
        chk("rr_cnt_mid", 32'(evt_cnt), 2);
        repeat (2) tick();
        chk("rr_cnt", 32'(evt_cnt), 3);
        chk("rr_sb_empty", 32'(sb.size()), 0);

        din = 4'b0000;
        repeat (2) tick();
        din = 4'b1001;
        push(2'd0, 1'b0);
        push(2'd3, 1'b0);
        repeat (5) tick();
        chk("wrap_rr_cnt", 32'(evt_cnt), 5);
        chk("wrap_rr_sb_empty", 32'(sb.size()), 0);

        edge_sel  = 8'h01;
        evt_ready = 1'b0;
        din = 4'b0000;
        tick();
        din[0] = 1'b1;
        push(2'd0, 1'b0);
        tick();
        din[0] = 1'b0;
        tick();
        chk("ovf_held_valid", 32'(evt_valid), 1);
        chk("ovf_held_type", 32'(evt_type), 0);
        chk("ovf_pend_loaded", 32'(pend), 0);
        din[0] = 1'b1;
        push(2'd0, 1'b0);
        tick();
        chk("ovf_second_pend", 32'(pend), 1);
        chk("ovf_second_ovf", 32'(overflow), 0);
        din[0] = 1'b0;
        tick();
        din[0] = 1'b1;
        tick();
        chk("ovf_third_ovf", 32'(overflow), 1);
        chk("ovf_third_pend", 32'(pend), 1);
        din[0] = 1'b0;
        tick();
        din[0] = 1'b1;
        tick();
        chk("ovf_fourth_ovf", 32'(overflow), 1);
        chk("ovf_fourth_pend", 32'(pend), 1);
        chk("ovf_held_ch", 32'(evt_ch), 0);
        evt_ready = 1'b1;
        repeat (3) tick();
        chk("ovf_drain_cnt", 32'(evt_cnt), 7);
        evt_ready = 1'b0;

        edge_sel = 8'h0C;
        din[1] = 1'b1;
        tick();
        chk("coll_pend", 32'(pend), 4'b0010);
        din[1] = 1'b0;
        push(2'd1, 1'b0);
        push(2'd1, 1'b1);
        tick();
        chk("coll_valid", 32'(evt_valid), 1);
        chk("coll_ch", 32'(evt_ch), 1);
        chk("coll_type", 32'(evt_type), 0);
        chk("coll_pend_reload", 32'(pend), 4'b0010);
        chk("coll_ovf", 32'(overflow), 4'b0001);
        evt_ready = 1'b1;
        repeat (3) tick();
        chk("coll_cnt", 32'(evt_cnt), 9);

        edge_sel = 8'h20;
        din[2] = 1'b1;
        tick();
        din[2] = 1'b0;
        push(2'd2, 1'b1);
        repeat (4) tick();
        chk("filt_cnt", 32'(evt_cnt), 10);
        chk("filt_pend", 32'(pend), 0);
        edge_sel = 8'h00;
        for (int p = 0; p < 2; p++) begin
            din[2] = 1'b1;
            tick();
            din[2] = 1'b0;
            tick();
        end
        tick();
        chk("off_pend", 32'(pend), 0);
        chk("off_valid", 32'(evt_valid), 0);
        chk("off_ovf", 32'(overflow), 4'b0001);
        chk("off_cnt", 32'(evt_cnt), 10);

        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_ovf", 32'(overflow), 0);
        chk("clr_cnt", 32'(evt_cnt), 0);

        edge_sel = 8'h01;
        din[0] = 1'b0;
        tick();
        for (int n = 0; n < 5; n++) begin
            din[0] = 1'b1;
            push(2'd0, 1'b0);
            tick();
            din[0] = 1'b0;
            tick();
        end
        repeat (2) tick();
        chk("five_cnt", 32'(evt_cnt), 5);

        evt_ready = 1'b0;
        edge_sel  = 8'h55;
        din = 4'b0001;
        push(2'd0, 1'b0);
        repeat (2) tick();
        din = 4'b0111;
        tick();
        chk("bp_pend", 32'(pend), 4'b0110);
        chk("bp_cnt", 32'(evt_cnt), 5);
        for (int n = 0; n < 10; n++) begin
            tick();
            chk("bp_valid", 32'(evt_valid), 1);
            chk("bp_ch", 32'(evt_ch), 0);
            chk("bp_type", 32'(evt_type), 0);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("bpclr_pend", 32'(pend), 0);
        chk("bpclr_ovf", 32'(overflow), 0);
        chk("bpclr_cnt", 32'(evt_cnt), 0);
        chk("bpclr_valid", 32'(evt_valid), 1);
        evt_ready = 1'b1;
        tick();
        chk("bpclr_hs_cnt", 32'(evt_cnt), 1);
        tick();
        chk("bpclr_idle_valid", 32'(evt_valid), 0);

        evt_ready = 1'b0;
        din = 4'b0000;
        tick();
        din[0] = 1'b1;
        push(2'd0, 1'b0);
        repeat (2) tick();
        clr = 1'b1;
        evt_ready = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_hs_same_cnt", 32'(evt_cnt), 1);

        edge_sel = 8'h01;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        din[0] = 1'b0;
        tick();
        for (int n = 0; n < 255; n++) begin
            din[0] = 1'b1;
            push(2'd0, 1'b0);
            tick();
            din[0] = 1'b0;
            tick();
        end
        repeat (2) tick();
        chk("cnt_255", 32'(evt_cnt), 255);
        din[0] = 1'b1;
        push(2'd0, 1'b0);
        tick();
        din[0] = 1'b0;
        repeat (3) tick();
        chk("cnt_wrap", 32'(evt_cnt), 0);
        chk("wrap_sb_empty", 32'(sb.size()), 0);

        edge_sel  = 8'h55;
        evt_ready = 1'b0;
        din = 4'b0001;
        push(2'd0, 1'b0);
        repeat (2) tick();
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        din = 4'b0011;
        push(2'd1, 1'b0);
        repeat (2) tick();
        din = 4'b0111;
        tick();
        chk("pre_rst_valid", 32'(evt_valid), 1);
        chk("pre_rst_ch", 32'(evt_ch), 1);
        chk("pre_rst_cnt", 32'(evt_cnt), 1);
        chk("pre_rst_pend", 32'(pend), 4'b0100);
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(evt_valid), 0);
        chk("midrst_ch", 32'(evt_ch), 0);
        chk("midrst_type", 32'(evt_type), 0);
        chk("midrst_pend", 32'(pend), 0);
        chk("midrst_ovf", 32'(overflow), 0);
        chk("midrst_cnt", 32'(evt_cnt), 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) tick();
        chk("post_rst_valid", 32'(evt_valid), 0);
        chk("post_rst_pend", 32'(pend), 0);
        chk("end_sb_empty", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
